// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared FSM state, stall-cause encoding and widths
`include "width_param.sv"

package pipe_ctrl_pkg;
  localparam int REG_W  = `REG_WIDTH;
  localparam int ADDR_W = `ADDR_WIDTH;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_REDIRECT = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE      = 2'd0,
    CAUSE_LOAD_USE  = 2'd1,
    CAUSE_EX_BUSY   = 2'd2,
    CAUSE_DMEM_WAIT = 2'd3
  } cause_t;

  // Only the highest-priority active cause steers the stage controls
  function automatic cause_t pick_cause(input logic dmem_wait, input logic ex_busy,
                                        input logic load_use);
    if (dmem_wait)     return CAUSE_DMEM_WAIT;
    else if (ex_busy)  return CAUSE_EX_BUSY;
    else if (load_use) return CAUSE_LOAD_USE;
    else               return CAUSE_NONE;
  endfunction
endpackage

// File: rtl/load_use_detect.sv
// rtl/load_use_detect.sv - tracks the load in EX and flags a dependent ID source
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic             id_r1_en,
  input  logic [REG_W-1:0] id_r1_addr,
  input  logic             id_r2_en,
  input  logic [REG_W-1:0] id_r2_addr,
  input  logic             id_rw_en,
  input  logic [REG_W-1:0] id_rw_addr,
  input  logic             id_is_load,
  input  logic             idex_stall,
  input  logic             idex_flush,
  output logic             load_use
);
  logic             ex_ld_vld;
  logic [REG_W-1:0] ex_ld_rd;

  // EX tracking only moves when ID actually advances into EX
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_ld_vld <= 1'b0;
      ex_ld_rd  <= '0;
    end else if (idex_flush) begin
      ex_ld_vld <= 1'b0;
    end else if (!idex_stall) begin
      ex_ld_vld <= id_valid & id_is_load & id_rw_en & (id_rw_addr != '0);
      ex_ld_rd  <= id_rw_addr;
    end
  end

  always_comb begin
    load_use = id_valid & ex_ld_vld & (ex_ld_rd != '0) &
               ((id_r1_en & (id_r1_addr == ex_ld_rd)) |
                (id_r2_en & (id_r2_addr == ex_ld_rd)));
  end
endmodule

// File: rtl/width_param.sv
// rtl/width_param.sv - shared register-index and address widths
`ifndef WIDTH_PARAM_SV
`define WIDTH_PARAM_SV
`define REG_WIDTH 5
`define ADDR_WIDTH 32
`endif

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline hazard/stall control with mispredict redirect FSM
`include "width_param.sv"

module pipe_ctrl
  import pipe_ctrl_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   id_valid,
  input  logic                   id_r1_en,
  input  logic [`REG_WIDTH-1:0]  id_r1_addr,
  input  logic                   id_r2_en,
  input  logic [`REG_WIDTH-1:0]  id_r2_addr,
  input  logic                   id_rw_en,
  input  logic [`REG_WIDTH-1:0]  id_rw_addr,
  input  logic                   id_is_load,
  input  logic                   id_predict_miss,
  input  logic [`ADDR_WIDTH-1:0] id_target,
  input  logic                   ex_busy,
  input  logic                   dmem_wait,
  input  logic                   pc_ready,
  output logic                   pc_stall,
  output logic                   ifid_stall,
  output logic                   ifid_flush,
  output logic                   idex_stall,
  output logic                   idex_flush,
  output logic                   exmem_stall,
  output logic                   exmem_flush,
  output logic                   memwb_flush,
  output logic                   redirect_valid,
  output logic [`ADDR_WIDTH-1:0] redirect_pc,
  output logic [31:0]            perf_stall_cnt,
  output logic [31:0]            perf_flush_cnt
);
  state_t state;
  cause_t cause;
  logic   load_use;
  logic   accept;

  load_use_detect u_load_use_detect (
    .clk        (clk),
    .rst        (rst),
    .id_valid   (id_valid),
    .id_r1_en   (id_r1_en),
    .id_r1_addr (id_r1_addr),
    .id_r2_en   (id_r2_en),
    .id_r2_addr (id_r2_addr),
    .id_rw_en   (id_rw_en),
    .id_rw_addr (id_rw_addr),
    .id_is_load (id_is_load),
    .idex_stall (idex_stall),
    .idex_flush (idex_flush),
    .load_use   (load_use)
  );

  always_comb begin
    cause       = rst ? CAUSE_NONE : pick_cause(dmem_wait, ex_busy, load_use);
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    ifid_flush  = 1'b0;
    idex_stall  = 1'b0;
    idex_flush  = 1'b0;
    exmem_stall = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    case (cause)
      CAUSE_DMEM_WAIT: begin
        pc_stall    = 1'b1;
        ifid_stall  = 1'b1;
        idex_stall  = 1'b1;
        exmem_stall = 1'b1;
        memwb_flush = 1'b1;
      end
      CAUSE_EX_BUSY: begin
        pc_stall    = 1'b1;
        ifid_stall  = 1'b1;
        idex_stall  = 1'b1;
        exmem_flush = 1'b1;
      end
      CAUSE_LOAD_USE: begin
        pc_stall    = 1'b1;
        ifid_stall  = 1'b1;
        idex_flush  = 1'b1;
      end
      default: ;
    endcase

    accept = !rst && (state == ST_RUN) && id_valid && id_predict_miss &&
             (cause == CAUSE_NONE);

    // While redirecting, fetch keeps running and IF/ID holds wrong-path only
    if (!rst && (state == ST_REDIRECT)) begin
      pc_stall   = 1'b0;
      ifid_stall = 1'b0;
      ifid_flush = 1'b1;
    end else if (accept) begin
      ifid_flush = 1'b1;
    end
  end

  assign redirect_valid = (state == ST_REDIRECT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_RUN;
      redirect_pc    <= '0;
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (pc_stall) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      case (state)
        ST_RUN: begin
          if (accept) begin
            state          <= ST_REDIRECT;
            redirect_pc    <= id_target;
            perf_flush_cnt <= perf_flush_cnt + 32'd1;
          end
        end
        ST_REDIRECT: begin
          if (pc_ready) state <= ST_RUN;
        end
        default: state <= ST_RUN;
      endcase
    end
  end
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - randomized scoreboard bench for pipe_ctrl
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  typedef struct packed {
    logic              rst;
    logic              id_valid;
    logic              r1_en;
    logic [REG_W-1:0]  r1;
    logic              r2_en;
    logic [REG_W-1:0]  r2;
    logic              rw_en;
    logic [REG_W-1:0]  rw;
    logic              is_load;
    logic              miss;
    logic [ADDR_W-1:0] target;
    logic              ex_busy;
    logic              dmem_wait;
    logic              pc_ready;
  } stim_t;

  typedef struct packed {
    logic [7:0]        ctl;
    logic              rv;
    logic [ADDR_W-1:0] rpc;
    logic [31:0]       scnt;
    logic [31:0]       fcnt;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              id_valid = 1'b0, id_r1_en = 1'b0, id_r2_en = 1'b0, id_rw_en = 1'b0;
  logic [REG_W-1:0]  id_r1_addr = '0, id_r2_addr = '0, id_rw_addr = '0;
  logic              id_is_load = 1'b0, id_predict_miss = 1'b0;
  logic [ADDR_W-1:0] id_target = '0;
  logic              ex_busy = 1'b0, dmem_wait = 1'b0, pc_ready = 1'b0;
  logic pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush;
  logic exmem_stall, exmem_flush, memwb_flush, redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic [31:0]       perf_stall_cnt, perf_flush_cnt;

  pipe_ctrl dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_r1_en(id_r1_en), .id_r1_addr(id_r1_addr),
    .id_r2_en(id_r2_en), .id_r2_addr(id_r2_addr),
    .id_rw_en(id_rw_en), .id_rw_addr(id_rw_addr), .id_is_load(id_is_load),
    .id_predict_miss(id_predict_miss), .id_target(id_target),
    .ex_busy(ex_busy), .dmem_wait(dmem_wait), .pc_ready(pc_ready),
    .pc_stall(pc_stall), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
    .idex_stall(idex_stall), .idex_flush(idex_flush),
    .exmem_stall(exmem_stall), .exmem_flush(exmem_flush), .memwb_flush(memwb_flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
  );

  always #5 clk = ~clk;

  // Stage action per cause, bit order {pc_s, ifid_s, ifid_f, idex_s, idex_f, exmem_s, exmem_f, memwb_f}
  localparam logic [7:0] PAT_DMEM = 8'b1101_0101;
  localparam logic [7:0] PAT_EX   = 8'b1101_0010;
  localparam logic [7:0] PAT_LU   = 8'b1100_1000;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  bit                m_redir;
  logic [ADDR_W-1:0] m_rpc;
  logic [31:0]       m_scnt, m_fcnt;
  bit                m_ld_vld;
  logic [REG_W-1:0]  m_ld_rd;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("stage_ctl", {56'd0, pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush,
                          exmem_stall, exmem_flush, memwb_flush}, {56'd0, e.ctl});
      check("redirect_valid", {63'd0, redirect_valid}, {63'd0, e.rv});
      check("redirect_pc", {32'd0, redirect_pc}, {32'd0, e.rpc});
      check("perf_stall_cnt", {32'd0, perf_stall_cnt}, {32'd0, e.scnt});
      check("perf_flush_cnt", {32'd0, perf_flush_cnt}, {32'd0, e.fcnt});
    end
  end

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    s.pc_ready = 1'b1;
    return s;
  endfunction

  task automatic step(input stim_t s);
    exp_t       e;
    logic [7:0] ctl;
    bit         hazard, accept;
    @(posedge clk);
    #1;
    rst = s.rst; id_valid = s.id_valid;
    id_r1_en = s.r1_en; id_r1_addr = s.r1; id_r2_en = s.r2_en; id_r2_addr = s.r2;
    id_rw_en = s.rw_en; id_rw_addr = s.rw; id_is_load = s.is_load;
    id_predict_miss = s.miss; id_target = s.target;
    ex_busy = s.ex_busy; dmem_wait = s.dmem_wait; pc_ready = s.pc_ready;

    hazard = s.id_valid && m_ld_vld &&
             ((s.r1_en && s.r1 == m_ld_rd) || (s.r2_en && s.r2 == m_ld_rd));
    if (s.rst)            ctl = 8'h00;
    else if (s.dmem_wait) ctl = PAT_DMEM;
    else if (s.ex_busy)   ctl = PAT_EX;
    else if (hazard)      ctl = PAT_LU;
    else                  ctl = 8'h00;
    accept = !s.rst && !m_redir && s.id_valid && s.miss && ctl == 8'h00;
    if (!s.rst && m_redir) ctl = (ctl & 8'h3F) | 8'h20;
    else if (accept)       ctl = ctl | 8'h20;

    e.ctl = ctl; e.rv = m_redir; e.rpc = m_rpc; e.scnt = m_scnt; e.fcnt = m_fcnt;
    exp_q.push_back(e);

    if (s.rst) begin
      m_redir = 0; m_rpc = '0; m_scnt = '0; m_fcnt = '0; m_ld_vld = 0; m_ld_rd = '0;
    end else begin
      if (ctl[7]) m_scnt = m_scnt + 1;
      if (ctl[3]) m_ld_vld = 0;
      else if (!ctl[4]) begin
        m_ld_vld = s.id_valid && s.is_load && s.rw_en && s.rw != 0;
        m_ld_rd  = s.rw;
      end
      if (accept) begin
        m_redir = 1; m_rpc = s.target; m_fcnt = m_fcnt + 1;
      end else if (m_redir && s.pc_ready) begin
        m_redir = 0;
      end
    end
  endtask

  function automatic stim_t load_to(input int rd);
    stim_t s;
    s = idle();
    s.id_valid = 1; s.rw_en = 1; s.rw = REG_W'(rd); s.is_load = 1;
    return s;
  endfunction

  function automatic stim_t use_r1(input int ra);
    stim_t s;
    s = idle();
    s.id_valid = 1; s.r1_en = 1; s.r1 = REG_W'(ra);
    return s;
  endfunction

  initial begin
    stim_t s;
    m_redir = 0; m_rpc = '0; m_scnt = '0; m_fcnt = '0; m_ld_vld = 0; m_ld_rd = '0;
    repeat (2) @(posedge clk);

    s = idle(); s.rst = 1; step(s);
    step(idle());

    // Load-use on r1 = 5: single stall cycle
    step(load_to(5));
    step(use_r1(5));
    step(use_r1(5));

    // Register 0 never hazards
    step(load_to(0));
    step(use_r1(0));

    // Mispredict with fetch holding off redirect for 3 cycles
    s = idle(); s.id_valid = 1; s.miss = 1; s.target = 32'h1C00_0040; s.pc_ready = 0;
    step(s);
    s = idle(); s.pc_ready = 0;
    repeat (3) step(s);
    step(idle());
    step(idle());

    // All three causes together, mispredict ignored
    step(load_to(3));
    s = use_r1(3); s.dmem_wait = 1; s.ex_busy = 1; s.miss = 1; s.target = 32'hDEAD_0000;
    step(s);
    s.dmem_wait = 0; s.ex_busy = 0; s.miss = 0;
    step(s);

    // Reset while redirecting abandons the redirect
    s = idle(); s.id_valid = 1; s.miss = 1; s.target = 32'h0000_1234; s.pc_ready = 0;
    step(s);
    s = idle(); s.pc_ready = 0;
    step(s);
    s.rst = 1;
    step(s);
    step(idle());

    // ex_busy holds the EX load, load-use returns once it drops
    step(load_to(7));
    s = use_r1(7); s.ex_busy = 1;
    repeat (4) step(s);
    s.ex_busy = 0;
    step(s);
    step(s);

    for (int i = 0; i < 2000; i++) begin
      s = idle();
      s.rst       = ($urandom_range(0, 99) == 0);
      s.id_valid  = ($urandom_range(0, 9) < 8);
      s.r1_en     = $urandom_range(0, 1);
      s.r1        = REG_W'($urandom_range(0, 3));
      s.r2_en     = $urandom_range(0, 1);
      s.r2        = REG_W'($urandom_range(0, 3));
      s.rw_en     = ($urandom_range(0, 3) != 0);
      s.rw        = REG_W'($urandom_range(0, 3));
      s.is_load   = ($urandom_range(0, 2) == 0);
      s.miss      = ($urandom_range(0, 4) == 0);
      s.target    = $urandom;
      s.ex_busy   = ($urandom_range(0, 6) == 0);
      s.dmem_wait = ($urandom_range(0, 9) == 0);
      s.pc_ready  = $urandom_range(0, 1);
      step(s);
    end

    repeat (3) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have one clock and synchronous active-high reset: clk  in  1  rising-edge clock; rst  in  1  synchronous, active-high reset.
REQ-002 SHALL have ID inputs: id_valid  in  1  ID holds a live instruction; id_r1_en/id_r2_en  in  1  source-read enables; id_r1_addr/id_r2_addr  in  `REG_WIDTH  source registers; id_rw_en  in  1  writes rd; id_rw_addr  in  `REG_WIDTH  dest register; id_is_load  in  1  instruction is a load.
REQ-003 SHALL have branch inputs: id_predict_miss  in  1  ID branch resolution disagrees with the fetch prediction; id_target  in  `ADDR_WIDTH  resolved next PC.
REQ-004 SHALL have backend inputs: ex_busy  in  1  multi-cycle MUL/DIV occupying EX; dmem_wait  in  1  MEM waiting on data memory; pc_ready  in  1  fetch accepts redirect.
REQ-005 SHALL have stage-control outputs, each 1 bit: pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall, exmem_flush, memwb_flush.
REQ-006 SHALL have redirect outputs: redirect_valid  out  1; redirect_pc  out  `ADDR_WIDTH.
REQ-007 SHALL have counters: perf_stall_cnt  out  32  cycles with pc_stall=1; perf_flush_cnt  out  32  accepted mispredicts.

Function
REQ-008 Stall causes SHALL be prioritised dmem_wait > ex_busy > load_use; only the highest active cause applies.
REQ-009 dmem_wait SHALL assert pc_stall, ifid_stall, idex_stall, exmem_stall, memwb_flush; all other stall/flush outputs 0 except REQ-015.
REQ-010 ex_busy (no dmem_wait) SHALL assert pc_stall, ifid_stall, idex_stall, exmem_flush.
REQ-011 load_use SHALL be id_valid & ex_ld_vld & ((id_r1_en & id_r1_addr==ex_ld_rd) | (id_r2_en & id_r2_addr==ex_ld_rd)); when selected, it SHALL assert pc_stall, ifid_stall, idex_flush.
REQ-012 ex_ld_vld/ex_ld_rd SHALL update only on ID->EX advance (idex_stall=0, idex_flush=0): ex_ld_vld <= id_valid & id_is_load & id_rw_en & (id_rw_addr!=0); cleared when idex_flush=1; held when idex_stall=1.
REQ-013 Register 0 SHALL never create a hazard.
REQ-014 FSM states RUN, REDIRECT; in RUN a mispredict SHALL be accepted iff id_valid & id_predict_miss & no stall cause active; acceptance SHALL assert ifid_flush that cycle, latch id_target into redirect_pc, increment perf_flush_cnt, go to REDIRECT.
REQ-015 In REDIRECT, redirect_valid=1, pc_stall=0, ifid_flush=1 every cycle (overrides ifid_stall); redirect_pc SHALL stay constant.
REQ-016 REDIRECT->RUN SHALL occur on the cycle redirect_valid & pc_ready (ifid_flush still 1 that cycle); redirect_valid=0 the next cycle.
REQ-017 id_predict_miss in REDIRECT, or with a stall cause active, SHALL be ignored (ID frozen or wrong-path).
REQ-018 Stall output overrides ex_busy/dmem_wait even in REDIRECT (REQ-009/010 apply to idex/exmem/memwb).
REQ-019 perf_stall_cnt SHALL increment by 1 each cycle pc_stall=1; both counters wrap at 2^32.
REQ-020 All outputs except counters and redirect_pc SHALL be combinational from state and inputs; no cause SHALL add latency beyond the cycle it is asserted.

Reset
REQ-021 On rst: state RUN, redirect_valid 0, redirect_pc 0, ex_ld_vld 0, ex_ld_rd 0, both counters 0; reset mid-REDIRECT SHALL abandon the redirect.
REQ-022 While rst=1, all stall/flush outputs SHALL be 0.

Structure
REQ-023 FSM state enum and stall-cause encoding (NONE, LOAD_USE, EX_BUSY, DMEM_WAIT) SHALL reside in shared package pipe_ctrl_pkg; widths SHALL come from width_param.sv.
REQ-024 Load-use comparison plus ex_ld tracking SHALL be sub-module load_use_detect.

Verification
REQ-025 EX load rd=5, ID r1_addr=5 -> one cycle pc_stall=ifid_stall=idex_flush=1, next cycle no stall; perf_stall_cnt=1.
REQ-026 EX load rd=0, ID r1_addr=0 -> no stall.
REQ-027 Mispredict id_target=0x1C000040, pc_ready low 3 cycles -> redirect_valid 3 cycles + handshake cycle, ifid_flush 5 cycles total, redirect_pc=0x1C000040, perf_flush_cnt=1.
REQ-028 dmem_wait and ex_busy and load_use together -> only dmem_wait pattern; id_predict_miss ignored.
REQ-029 rst asserted during REDIRECT -> redirect_valid=0 next cycle, state RUN, counters 0.
REQ-030 ex_busy 4 cycles following a load to rd=7 in EX -> ex_ld_vld held, load-use stall resumes after ex_busy drops.
